// File: rtl/pattern_sequencer_pkg.sv
// Shared definitions for the test-pattern sequencer: pattern IDs, display
// mode encoding, frame-counter width and the hold-count helper.
package pattern_sequencer_pkg;

    // Frame-counter and hold-register width.
    localparam int unsigned CNT_W = 8;

    // Beam position width, as produced by hvsync_generator.
    localparam int unsigned POS_W = 9;

    // Pattern identifiers.
    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_CHECK = 2'd1;
    localparam logic [1:0] PAT_WHITE = 2'd2;
    localparam logic [1:0] PAT_RAMP  = 2'd3;

    // Display mode. A pending configuration is tracked by a separate flag,
    // so it can coexist with either mode.
    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } mode_t;

    // A hold of zero frames behaves like a hold of one frame.
    function automatic logic [CNT_W-1:0] hold_eff(input logic [CNT_W-1:0] hold);
        return (hold == '0) ? CNT_W'(1) : hold;
    endfunction

endpackage

// File: rtl/pattern_gen.sv
// Combinational pixel generator: maps beam position and pattern ID to a
// raw {r,g,b} value. No registers live here.
import pattern_sequencer_pkg::*;

module pattern_gen (
    input  logic [POS_W-1:0] hpos,
    input  logic [POS_W-1:0] vpos,
    input  logic [1:0]       pattern_id,
    output logic [2:0]       rgb
);

    // Position bits that no pattern looks at.
    logic unused_pos_bits;
    assign unused_pos_bits = ^{hpos[8], hpos[3:0], vpos[8:5], vpos[3:0]};

    // Select the pixel for the current pattern.
    always_comb begin
        rgb = '0;
        case (pattern_id)
            PAT_BARS:  rgb = {~hpos[6], ~hpos[7], ~hpos[5]};
            PAT_CHECK: rgb = {3{hpos[4] ^ vpos[4]}};
            PAT_WHITE: rgb = '1;
            PAT_RAMP:  rgb = hpos[7:5];
            default:   rgb = '0;
        endcase
    end

endmodule

// File: rtl/pattern_sequencer.sv
// Test-pattern sequencer: holds the active pattern, accepts configuration
// requests into shadow registers, applies them at the next frame boundary,
// auto-cycles patterns in auto mode and registers the gated pixel output.
import pattern_sequencer_pkg::*;

module pattern_sequencer (
    input  logic             clk,
    input  logic             reset,
    input  logic             vsync,
    input  logic             display_on,
    input  logic [POS_W-1:0] hpos,
    input  logic [POS_W-1:0] vpos,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_auto,
    input  logic [1:0]       cfg_pattern,
    input  logic [CNT_W-1:0] cfg_hold,
    output logic [2:0]       rgb,
    output logic [1:0]       pattern_id,
    output logic             frame_start
);

    // Frame-edge detection.
    logic             vsync_q;

    // Active configuration.
    mode_t            mode_q,     mode_d;
    logic [1:0]       pattern_q,  pattern_d;
    logic [CNT_W-1:0] hold_q,     hold_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    // Shadow configuration waiting for the next frame boundary.
    logic             pending_q,  pending_d;
    logic             sh_auto_q,  sh_auto_d;
    logic [1:0]       sh_pat_q,   sh_pat_d;
    logic [CNT_W-1:0] sh_hold_q,  sh_hold_d;

    // Pixel path.
    logic [2:0]       rgb_raw;
    logic [2:0]       rgb_q,      rgb_d;

    logic             accept;
    logic             apply;

    // Rising edge of vsync marks the start of a frame.
    assign frame_start = vsync & ~vsync_q;

    assign cfg_ready   = ~pending_q;
    assign pattern_id  = pattern_q;
    assign rgb         = rgb_q;

    // A request is taken only when the shadow slot is empty; requests
    // arriving while a configuration is pending are dropped.
    assign accept = cfg_valid & ~pending_q;

    // pending_q is registered, so an accept that coincides with
    // frame_start cannot be applied until the following frame edge.
    assign apply  = frame_start & pending_q;

    pattern_gen u_pattern_gen (
        .hpos       (hpos),
        .vpos       (vpos),
        .pattern_id (pattern_q),
        .rgb        (rgb_raw)
    );

    // Next-state logic for mode, pattern, counters and shadow registers.
    always_comb begin
        mode_d    = mode_q;
        pattern_d = pattern_q;
        hold_d    = hold_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        sh_auto_d = sh_auto_q;
        sh_pat_d  = sh_pat_q;
        sh_hold_d = sh_hold_q;

        if (accept) begin
            pending_d = 1'b1;
            sh_auto_d = cfg_auto;
            sh_pat_d  = cfg_pattern;
            sh_hold_d = cfg_hold;
        end

        // Applying a configuration takes priority over an auto-advance
        // falling due in the same frame_start cycle.
        if (apply) begin
            pending_d = 1'b0;
            mode_d    = sh_auto_q ? MODE_AUTO : MODE_MANUAL;
            hold_d    = sh_hold_q;
            pattern_d = sh_auto_q ? PAT_BARS : sh_pat_q;
            cnt_d     = '0;
        end else if (frame_start && (mode_q == MODE_AUTO)) begin
            if (cnt_q >= (hold_eff(hold_q) - CNT_W'(1))) begin
                pattern_d = pattern_q + 2'd1;
                cnt_d     = '0;
            end else begin
                cnt_d     = cnt_q + CNT_W'(1);
            end
        end
    end

    // Pixel output is blanked outside the visible region.
    always_comb begin
        rgb_d = '0;
        if (display_on) begin
            rgb_d = rgb_raw;
        end
    end

    // State and configuration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q   <= 1'b0;
            mode_q    <= MODE_MANUAL;
            pattern_q <= PAT_BARS;
            hold_q    <= CNT_W'(1);
            cnt_q     <= '0;
            pending_q <= 1'b0;
            sh_auto_q <= 1'b0;
            sh_pat_q  <= PAT_BARS;
            sh_hold_q <= CNT_W'(1);
        end else begin
            vsync_q   <= vsync;
            mode_q    <= mode_d;
            pattern_q <= pattern_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            sh_auto_q <= sh_auto_d;
            sh_pat_q  <= sh_pat_d;
            sh_hold_q <= sh_hold_d;
        end
    end

    // Registered pixel output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed self-checking bench for pattern_sequencer.
module tb_pattern_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       vsync;
    logic       display_on;
    logic [8:0] hpos;
    logic [8:0] vpos;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_auto;
    logic [1:0] cfg_pattern;
    logic [7:0] cfg_hold;
    logic [2:0] rgb;
    logic [1:0] pattern_id;
    logic       frame_start;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pattern_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .vsync       (vsync),
        .display_on  (display_on),
        .hpos        (hpos),
        .vpos        (vpos),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_auto    (cfg_auto),
        .cfg_pattern (cfg_pattern),
        .cfg_hold    (cfg_hold),
        .rgb         (rgb),
        .pattern_id  (pattern_id),
        .frame_start (frame_start)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_frame();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic do_cfg(input logic a, input logic [1:0] p, input logic [7:0] h);
        cfg_auto    = a;
        cfg_pattern = p;
        cfg_hold    = h;
        cfg_valid   = 1'b1;
        tick();
        cfg_valid   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; vsync = 1'b0; display_on = 1'b0; hpos = '0; vpos = '0;
        cfg_valid = 1'b0; cfg_auto = 1'b0; cfg_pattern = '0; cfg_hold = '0;
        #2;
        tests++; if (rgb !== 3'b000) begin fails++; $display("FAIL reset_rgb got=%b exp=000", rgb); end
        tests++; if (pattern_id !== 2'd0) begin fails++; $display("FAIL reset_pat got=%0d exp=0", pattern_id); end
        tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
        tests++; if (frame_start !== 1'b0) begin fails++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_pixels();
        display_on = 1'b0; hpos = 9'd0; tick();
        tests++; if (rgb !== 3'b000) begin fails++; $display("FAIL pix_blank got=%b exp=000", rgb); end
        display_on = 1'b1; hpos = 9'd0; tick();
        tests++; if (rgb !== 3'b111) begin fails++; $display("FAIL pix_h0 got=%b exp=111", rgb); end
        hpos = 9'd192; tick();
        tests++; if (rgb !== 3'b001) begin fails++; $display("FAIL pix_h192 got=%b exp=001", rgb); end
        hpos = 9'd32; tick();
        tests++; if (rgb !== 3'b110) begin fails++; $display("FAIL pix_h32 got=%b exp=110", rgb); end
        display_on = 1'b0; tick();
        tests++; if (rgb !== 3'b000) begin fails++; $display("FAIL pix_off got=%b exp=000", rgb); end
    endtask

    task automatic test_manual();
        display_on = 1'b1; hpos = 9'd192; vpos = 9'd0;
        do_cfg(1'b0, 2'd2, 8'd1);
        tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL man_ready_lo got=%b exp=0", cfg_ready); end
        repeat (4) tick();
        tests++; if (pattern_id !== 2'd0) begin fails++; $display("FAIL man_hold got=%0d exp=0", pattern_id); end
        tests++; if (rgb !== 3'b001) begin fails++; $display("FAIL man_old_rgb got=%b exp=001", rgb); end
        vsync = 1'b1; #1;
        tests++; if (frame_start !== 1'b1) begin fails++; $display("FAIL man_fs got=%b exp=1", frame_start); end
        tick(); vsync = 1'b0;
        tests++; if (pattern_id !== 2'd2) begin fails++; $display("FAIL man_apply got=%0d exp=2", pattern_id); end
        tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL man_ready_hi got=%b exp=1", cfg_ready); end
        tests++; if (frame_start !== 1'b0) begin fails++; $display("FAIL man_fs_pulse got=%b exp=0", frame_start); end
        tick();
        tests++; if (rgb !== 3'b111) begin fails++; $display("FAIL man_white got=%b exp=111", rgb); end
        do_cfg(1'b0, 2'd1, 8'd1); do_frame();
        hpos = 9'd16; vpos = 9'd0; tick();
        tests++; if (rgb !== 3'b111) begin fails++; $display("FAIL chk_a got=%b exp=111", rgb); end
        vpos = 9'd16; tick();
        tests++; if (rgb !== 3'b000) begin fails++; $display("FAIL chk_b got=%b exp=000", rgb); end
        do_cfg(1'b0, 2'd3, 8'd1); do_frame();
        hpos = 9'd160; tick();
        tests++; if (rgb !== 3'b101) begin fails++; $display("FAIL ramp got=%b exp=101", rgb); end
    endtask

    task automatic test_auto();
        logic [1:0] exp;
        do_cfg(1'b1, 2'd2, 8'd3);
        do_frame();
        tests++; if (pattern_id !== 2'd0) begin fails++; $display("FAIL auto_start got=%0d exp=0", pattern_id); end
        for (int k = 1; k <= 12; k++) begin
            do_frame();
            exp = 2'((k / 3) % 4);
            tests++; if (pattern_id !== exp) begin fails++; $display("FAIL auto_h3 frame=%0d got=%0d exp=%0d", k, pattern_id, exp); end
        end
    endtask

    task automatic test_auto_hold0();
        logic [1:0] exp;
        do_cfg(1'b1, 2'd3, 8'd0);
        do_frame();
        tests++; if (pattern_id !== 2'd0) begin fails++; $display("FAIL h0_start got=%0d exp=0", pattern_id); end
        for (int k = 1; k <= 5; k++) begin
            do_frame();
            exp = 2'(k % 4);
            tests++; if (pattern_id !== exp) begin fails++; $display("FAIL auto_h0 frame=%0d got=%0d exp=%0d", k, pattern_id, exp); end
        end
        // pattern is 1 and an advance to 2 is due; the manual config must win
        do_cfg(1'b0, 2'd3, 8'd1);
        do_frame();
        tests++; if (pattern_id !== 2'd3) begin fails++; $display("FAIL cfg_wins got=%0d exp=3", pattern_id); end
        do_frame();
        tests++; if (pattern_id !== 2'd3) begin fails++; $display("FAIL manual_stay got=%0d exp=3", pattern_id); end
    endtask

    task automatic test_collision();
        vsync = 1'b1; cfg_valid = 1'b1; cfg_auto = 1'b0; cfg_pattern = 2'd1;
        #1;
        tests++; if (frame_start !== 1'b1) begin fails++; $display("FAIL col_fs got=%b exp=1", frame_start); end
        tick();
        vsync = 1'b0; cfg_valid = 1'b0;
        tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL col_ready got=%b exp=0", cfg_ready); end
        tests++; if (pattern_id !== 2'd3) begin fails++; $display("FAIL col_wait got=%0d exp=3", pattern_id); end
        repeat (2) tick();
        do_frame();
        tests++; if (pattern_id !== 2'd1) begin fails++; $display("FAIL col_apply got=%0d exp=1", pattern_id); end
        tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL col_ready2 got=%b exp=1", cfg_ready); end
    endtask

    task automatic test_back_to_back();
        do_cfg(1'b0, 2'd2, 8'd1);
        do_cfg(1'b0, 2'd0, 8'd1);
        tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready got=%b exp=0", cfg_ready); end
        do_frame();
        tests++; if (pattern_id !== 2'd2) begin fails++; $display("FAIL b2b_first got=%0d exp=2", pattern_id); end
        do_frame();
        tests++; if (pattern_id !== 2'd2) begin fails++; $display("FAIL b2b_ignored got=%0d exp=2", pattern_id); end
    endtask

    task automatic test_reset_pending();
        display_on = 1'b1; hpos = 9'd0; vpos = 9'd0;
        do_cfg(1'b0, 2'd1, 8'd1);
        tick();
        tests++; if (rgb !== 3'b111) begin fails++; $display("FAIL rp_pre got=%b exp=111", rgb); end
        #3;
        reset = 1'b1;
        #1;
        tests++; if (rgb !== 3'b000) begin fails++; $display("FAIL rp_rgb got=%b exp=000", rgb); end
        tests++; if (pattern_id !== 2'd0) begin fails++; $display("FAIL rp_pat got=%0d exp=0", pattern_id); end
        tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL rp_ready got=%b exp=1", cfg_ready); end
        tests++; if (frame_start !== 1'b0) begin fails++; $display("FAIL rp_fs got=%b exp=0", frame_start); end
        tick();
        reset = 1'b0;
        do_frame();
        do_frame();
        tests++; if (pattern_id !== 2'd0) begin fails++; $display("FAIL rp_dropped got=%0d exp=0", pattern_id); end
        tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL rp_ready2 got=%b exp=1", cfg_ready); end
        hpos = 9'd192; tick();
        tests++; if (rgb !== 3'b001) begin fails++; $display("FAIL rp_bars got=%b exp=001", rgb); end
    endtask

    initial begin
        test_reset();
        test_pixels();
        test_manual();
        test_auto();
        test_auto_hold0();
        test_collision();
        test_back_to_back();
        test_reset_pending();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 SHALL have `clk`, input, 1 bit: the single clock, the same pixel clock that drives `hvsync_generator`.
REQ-002 SHALL have `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have `vsync`, input, 1 bit: from `hvsync_generator`, synchronous to `clk`, active high.
REQ-004 SHALL have `display_on`, input, 1 bit: visible-region flag.
REQ-005 SHALL have `hpos`, input, 9 bits: beam horizontal position.
REQ-006 SHALL have `vpos`, input, 9 bits: beam vertical position.
REQ-007 SHALL have `cfg_valid`, input, 1 bit: configuration request.
REQ-008 SHALL have `cfg_ready`, output, 1 bit: configuration slot free.
REQ-009 SHALL have `cfg_auto`, input, 1 bit: 1 = auto-cycle mode, 0 = manual mode.
REQ-010 SHALL have `cfg_pattern`, input, 2 bits: pattern to select in manual mode.
REQ-011 SHALL have `cfg_hold`, input, 8 bits: frames per pattern in auto mode.
REQ-012 SHALL have `rgb`, output, 3 bits: {r,g,b} pixel, registered.
REQ-013 SHALL have `pattern_id`, output, 2 bits: the pattern currently shown.
REQ-014 SHALL have `frame_start`, output, 1 bit: one-cycle pulse at each vsync rising edge.

Function
REQ-015 Patterns SHALL be:
- 0 = colour bars: r=~hpos[6], g=~hpos[7], b=~hpos[5].
- 1 = checkerboard: all three bits = hpos[4]^vpos[4].
- 2 = solid white: 3'b111.
- 3 = ramp: hpos[7:5].
REQ-016 `rgb` SHALL equal the selected pattern gated by `display_on`, registered, with 1-cycle latency from `hpos`/`vpos`/`display_on`; `rgb` SHALL be 3'b000 whenever the registered `display_on` is 0.
REQ-017 The frame boundary SHALL be detected as `vsync` rising edge (registered previous `vsync`); `frame_start` SHALL pulse high in the cycle `vsync`=1 while the previous value was 0.
REQ-018 A configuration SHALL be accepted when `cfg_valid` && `cfg_ready`; the values SHALL be captured into shadow registers and a pending flag SHALL be set.
REQ-019 `cfg_ready` SHALL be the inverse of the pending flag; `cfg_valid` while `cfg_ready`=0 SHALL be ignored, with no stall or loss of the already-pending configuration.
REQ-020 A pending configuration SHALL be applied only on the first `frame_start` strictly after the acceptance cycle; an accept coinciding with `frame_start` SHALL wait for the next edge. When applied:
- the pending flag clears;
- the mode updates;
- in manual mode, `pattern_id` is set to the shadow `cfg_pattern`;
- in auto mode, `pattern_id` is set to 0;
- the hold counter clears.
REQ-021 The state machine SHALL have three states: MANUAL, AUTO and PENDING_APPLY. PENDING_APPLY is an orthogonal flag, not an exclusive state. Transitions SHALL occur only on `frame_start`.
REQ-022 In AUTO, on each `frame_start` with nothing pending, the 8-bit frame counter SHALL increment. When the counter reaches hold-1, the next `frame_start` SHALL advance `pattern_id` by 1 and clear the counter. `cfg_hold`=0 SHALL be treated as 1.
REQ-023 `pattern_id` SHALL wrap 3 -> 0; the frame counter SHALL never exceed 255.
REQ-024 `pattern_id` SHALL change only in a `frame_start` cycle, so a pattern never changes mid-frame.
REQ-025 When a configuration is applied and an auto-advance are due in the same `frame_start` cycle, the configuration SHALL win and the auto-advance SHALL be discarded.

Reset
REQ-026 On `reset` assertion, with no clock, the block SHALL asynchronously set:
- `rgb` = 0;
- `pattern_id` = 0;
- mode = MANUAL;
- frame counter = 0;
- pending = 0, so `cfg_ready` = 1;
- previous-`vsync` = 0, so `frame_start` = 0.
REQ-027 `reset` asserted mid-frame or with a configuration pending SHALL discard the pending configuration; after release the block SHALL show pattern 0 until the first configuration is applied.
REQ-028 The shadow configuration registers SHALL also reset: auto = 0, pattern = 0, hold = 1.

Structure
REQ-029 A shared package SHALL hold the pattern ID constants (PAT_BARS, PAT_CHECK, PAT_WHITE, PAT_RAMP), the mode encoding, and the counter width (8).
REQ-030 Pixel generation SHALL live in one combinational sub-module, `pattern_gen` (inputs `hpos`, `vpos`, `pattern_id`; output raw `rgb`). The sequencer SHALL own all registers.

Verification
REQ-031 Reset release: `rgb`=0 while `display_on`=0; at `hpos`=0, `display_on`=1, `rgb`=3'b111 one cycle later; at `hpos`=192, `rgb`=3'b001 (blue bar).
REQ-032 Manual config: accept `cfg_pattern`=2 mid-frame -> `cfg_ready`=0, `pattern_id` stays 0 until the next `frame_start`, then becomes 2 and `cfg_ready`=1.
REQ-033 Auto mode with `cfg_hold`=3: `pattern_id` sequence 0,0,0,1,1,1,2,2,2,3,3,3,0 over 13 frames; `cfg_hold`=0 -> the pattern advances every frame.
REQ-034 Collision cases:
- accept in the same cycle as `frame_start` -> applied one frame later;
- second `cfg_valid` while pending -> ignored, and the first configuration is applied.
REQ-035 Reset asserted between clock edges with a configuration pending -> all outputs 0 immediately, `cfg_ready`=1, and the dropped configuration is never applied.
